// File: rtl/count_display_drv.sv
// Two-digit multiplexed 7-segment driver for a 4-bit count arriving from another clock domain.
// The count is synchronised, debounced to two matching samples, split into tens/units and scanned.
module count_display_drv #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cnt_in,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       new_val,
   output logic       wrap
);

   localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   logic [3:0]    s1, s2, s3;
   logic [3:0]    disp_val;
   logic [CW-1:0] refresh_cnt;
   logic          sel;
   logic          accept;
   logic          tens;
   logic [3:0]    units;
   logic [3:0]    digit;

   // A value is taken only once two consecutive synchronised samples agree
   assign accept = (s2 == s3) && (s3 != disp_val);

   // Synchroniser, acceptance and event pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         s1       <= '0;
         s2       <= '0;
         s3       <= '0;
         disp_val <= '0;
         new_val  <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         s1      <= cnt_in;
         s2      <= s1;
         s3      <= s2;
         new_val <= accept;
         wrap    <= accept && (s3 == 4'd0) && (disp_val == 4'd15);
         if (accept)
            disp_val <= s3;
      end
   end

   // Free-running scan timer; digit select flips on every wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_cnt <= '0;
         sel         <= 1'b0;
      end else if (refresh_cnt == LAST) begin
         refresh_cnt <= '0;
         sel         <= ~sel;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   assign tens  = (disp_val >= 4'd10);
   assign units = tens ? (disp_val - 4'd10) : disp_val;
   assign digit = sel ? {3'b000, tens} : units;
   assign an    = sel ? 2'b01 : 2'b10;

   // Segment decode from registered state; a zero tens digit is blanked
   always_comb begin
      seg = 7'b1111111;
      if (!(sel && !tens)) begin
         case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
         endcase
      end
   end

endmodule
